// File: rtl/wb_dma_chunk_xfer_pkg.sv
// -----------------------------------------------------------------------------
// wb_dma_chunk_xfer_pkg
// Shared definitions for the chunk transfer engine: FSM state encodings,
// the per-word address step and a chunk-size legality helper.
// No ports (package).
// -----------------------------------------------------------------------------
package wb_dma_chunk_xfer_pkg;

    // Control FSM states: read burst, settle gap, write burst, settle gap.
    typedef enum logic [2:0] {
        CX_IDLE   = 3'd0,
        CX_RD     = 3'd1,
        CX_RD_GAP = 3'd2,
        CX_WR     = 3'd3,
        CX_WR_GAP = 3'd4
    } cx_state_t;

    // Byte distance between consecutive 32-bit words.
    localparam logic [31:0] ADR_STEP = 32'd4;

    // A chunk is legal when it holds at least one word and fits the buffer.
    function automatic logic sz_ok(input logic [31:0] sz, input int dl);
        return (sz != 32'd0) && (sz <= (32'd1 << dl));
    endfunction

endpackage

// File: rtl/wb_dma_chunk_xfer_buf.sv
// -----------------------------------------------------------------------------
// wb_dma_chunk_xfer_buf
// 2**DL x 32 register file holding one chunk between the read and write
// bursts. Synchronous write, asynchronous read; contents are never reset.
// Ports:
//   clk    in  1    system clock
//   we     in  1    write enable
//   waddr  in  DL   write index
//   wdata  in  32   write data
//   raddr  in  DL   read index
//   rdata  out 32   read data (combinational)
// -----------------------------------------------------------------------------
module wb_dma_chunk_xfer_buf #(
    parameter int DL = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [DL-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [DL-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [2**DL];

    // Capture one read beat into the buffer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/wb_dma_chunk_xfer.sv
// -----------------------------------------------------------------------------
// wb_dma_chunk_xfer
// Chunk engine in front of wb_dma_wb_mast: one accepted start reads up to
// 2**DL words from src_adr into a local buffer, then writes them to dst_adr,
// and ends with a one-cycle done (or err on a bus error) pulse.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               1-cycle request, honoured only in IDLE with a legal size
//   src_adr, dst_adr    byte addresses, sampled on an accepted start
//   src_inc, dst_inc    1: address advances by 4 per word, 0: fixed
//   chunk_sz            words to move, 1..2**DL
//   busy, done, err     status (busy level, done/err pulses)
//   mast_go/we/adr      registered master controls
//   mast_din            write data = buffer[rd_ptr]
//   mast_dout/drdy/err  master read data, beat ack, bus error
//   mast_wait           combinational stb suppression on the final beat / error
// -----------------------------------------------------------------------------
module wb_dma_chunk_xfer
    import wb_dma_chunk_xfer_pkg::*;
#(
    parameter int DL = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   src_adr,
    input  logic [31:0]   dst_adr,
    input  logic          src_inc,
    input  logic          dst_inc,
    input  logic [DL:0]   chunk_sz,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mast_go,
    output logic          mast_we,
    output logic [31:0]   mast_adr,
    output logic [31:0]   mast_din,
    input  logic [31:0]   mast_dout,
    input  logic          mast_drdy,
    input  logic          mast_err,
    output logic          mast_wait
);

    localparam logic [DL:0]   CNT_ONE  = {{DL{1'b0}}, 1'b1};
    localparam logic [DL-1:0] PTR_ONE  = {{(DL-1){1'b0}}, 1'b1};
    localparam logic [DL-1:0] PTR_ZERO = {DL{1'b0}};

    cx_state_t     state_r, state_nxt_s;
    logic [DL:0]   cnt_r, sz_r;
    logic [DL-1:0] wr_ptr_r, rd_ptr_r;
    logic [31:0]   adr_r, dst_adr_r;
    logic          src_inc_r, dst_inc_r;
    logic          busy_r, done_r, err_r, go_r, we_r;
    logic          busy_nxt_s, done_nxt_s, err_nxt_s, go_nxt_s, we_nxt_s;
    logic          start_ok_s, last_s, beat_s, in_xfer_s, buf_we_s;

    assign start_ok_s = start && sz_ok({{(31-DL){1'b0}}, chunk_sz}, DL);
    assign last_s     = (cnt_r == CNT_ONE);
    // An error in the same cycle as an ack wins: the beat is not counted.
    assign beat_s     = mast_drdy && !mast_err;
    assign in_xfer_s  = (state_r == CX_RD) || (state_r == CX_WR);
    assign buf_we_s   = (state_r == CX_RD) && beat_s;

    // Drop the master's next stb after the final ack or on an error.
    assign mast_wait  = in_xfer_s && (mast_err || (mast_drdy && last_s));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= CX_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            CX_IDLE: begin
                if (start_ok_s) state_nxt_s = CX_RD;
                else            state_nxt_s = CX_IDLE;
            end
            CX_RD: begin
                if (mast_err)              state_nxt_s = CX_IDLE;
                else if (beat_s && last_s) state_nxt_s = CX_RD_GAP;
                else                       state_nxt_s = CX_RD;
            end
            CX_RD_GAP: state_nxt_s = CX_WR;
            CX_WR: begin
                if (mast_err)              state_nxt_s = CX_IDLE;
                else if (beat_s && last_s) state_nxt_s = CX_WR_GAP;
                else                       state_nxt_s = CX_WR;
            end
            CX_WR_GAP: state_nxt_s = CX_IDLE;
            default:   state_nxt_s = CX_IDLE;
        endcase
    end

    // Next values of the registered status and master control outputs.
    always_comb begin
        go_nxt_s   = go_r;
        we_nxt_s   = we_r;
        busy_nxt_s = busy_r;
        done_nxt_s = 1'b0;
        err_nxt_s  = 1'b0;
        case (state_r)
            CX_IDLE: begin
                if (start_ok_s) begin
                    go_nxt_s   = 1'b1;
                    we_nxt_s   = 1'b0;
                    busy_nxt_s = 1'b1;
                end else begin
                    go_nxt_s   = 1'b0;
                    we_nxt_s   = 1'b0;
                    busy_nxt_s = 1'b0;
                end
            end
            CX_RD, CX_WR: begin
                if (mast_err) begin
                    go_nxt_s   = 1'b0;
                    we_nxt_s   = 1'b0;
                    busy_nxt_s = 1'b0;
                    err_nxt_s  = 1'b1;
                end else if (beat_s && last_s) begin
                    go_nxt_s   = 1'b0;
                end else begin
                    go_nxt_s   = 1'b1;
                end
            end
            CX_RD_GAP: begin
                go_nxt_s = 1'b1;
                we_nxt_s = 1'b1;
            end
            CX_WR_GAP: begin
                go_nxt_s   = 1'b0;
                we_nxt_s   = 1'b0;
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b1;
            end
            default: begin
                go_nxt_s   = 1'b0;
                we_nxt_s   = 1'b0;
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go_r   <= 1'b0;
            we_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            go_r   <= go_nxt_s;
            we_r   <= we_nxt_s;
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            err_r  <= err_nxt_s;
        end
    end

    // Address, word counter, buffer pointers and latched chunk configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_r     <= 32'd0;
            cnt_r     <= {(DL+1){1'b0}};
            sz_r      <= {(DL+1){1'b0}};
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            dst_adr_r <= 32'd0;
            src_inc_r <= 1'b0;
            dst_inc_r <= 1'b0;
        end else begin
            case (state_r)
                CX_IDLE: begin
                    if (start_ok_s) begin
                        adr_r     <= src_adr;
                        cnt_r     <= chunk_sz;
                        sz_r      <= chunk_sz;
                        wr_ptr_r  <= PTR_ZERO;
                        dst_adr_r <= dst_adr;
                        src_inc_r <= src_inc;
                        dst_inc_r <= dst_inc;
                    end
                end
                CX_RD: begin
                    if (beat_s) begin
                        wr_ptr_r <= wr_ptr_r + PTR_ONE;
                        cnt_r    <= cnt_r - CNT_ONE;
                        adr_r    <= adr_r + (src_inc_r ? ADR_STEP : 32'd0);
                    end
                end
                CX_RD_GAP: begin
                    adr_r    <= dst_adr_r;
                    cnt_r    <= sz_r;
                    rd_ptr_r <= PTR_ZERO;
                end
                CX_WR: begin
                    if (beat_s) begin
                        rd_ptr_r <= rd_ptr_r + PTR_ONE;
                        cnt_r    <= cnt_r - CNT_ONE;
                        adr_r    <= adr_r + (dst_inc_r ? ADR_STEP : 32'd0);
                    end
                end
                default: begin
                    adr_r <= adr_r;
                end
            endcase
        end
    end

    wb_dma_chunk_xfer_buf #(.DL(DL)) u_buf (
        .clk   (clk),
        .we    (buf_we_s),
        .waddr (wr_ptr_r),
        .wdata (mast_dout),
        .raddr (rd_ptr_r),
        .rdata (mast_din)
    );

    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign mast_go  = go_r;
    assign mast_we  = we_r;
    assign mast_adr = adr_r;

endmodule
